// File: rtl/alu_issue_ctrl.sv
// Issue controller that decodes one MIPS R-type funct, drives a shared ALU and forms the result.
// Latency: accept edge T, result valid in the cycle after edge T+1 (2 cycles), one op per 3 cycles.
// Backpressure: result is held in DONE until out_ready; in_ready is low everywhere except IDLE.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_word1,
  output logic [31:0] alu_word2,
  output logic [1:0]  alu_op,
  output logic        alu_bitinvert,
  input  logic [31:0] alu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_err
);

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] word1_q, word2_q;
  logic [1:0]  op_q;
  logic        inv_q;
  logic        nor_q, slt_q, err_q;
  logic [31:0] result_q, result_d;
  logic        out_err_q;

  logic [1:0]  dec_op;
  logic        dec_inv, dec_nor, dec_slt, dec_err;
  logic        accept;
  logic        slt_bit;

  assign accept = in_valid & in_ready;

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: one cycle in ISSUE, then wait in DONE for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_ISSUE;
      S_ISSUE:                state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Handshake outputs; in_ready is masked by reset so it reads 0 while rst_n is low.
  always_comb begin
    in_ready  = rst_n & (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Funct decode into ALU controls plus result-forming flags.
  always_comb begin
    dec_op  = 2'b00;
    dec_inv = 1'b0;
    dec_nor = 1'b0;
    dec_slt = 1'b0;
    dec_err = 1'b0;
    case (in_funct)
      FN_ADD: dec_op = 2'b10;
      FN_SUB: begin dec_op = 2'b10; dec_inv = 1'b1; end
      FN_AND: dec_op = 2'b00;
      FN_OR:  dec_op = 2'b01;
      FN_NOR: begin dec_op = 2'b01; dec_nor = 1'b1; end
      FN_SLT: begin dec_op = 2'b10; dec_inv = 1'b1; dec_slt = 1'b1; end
      default: dec_err = 1'b1;
    endcase
  end

  // SLT: when operand signs differ the subtraction may overflow, so the sign of A decides.
  assign slt_bit = (word1_q[31] ^ word2_q[31]) ? word1_q[31] : alu_out[31];

  // Result formation from the ALU output for the captured operation.
  always_comb begin
    result_d = alu_out;
    if (err_q)      result_d = 32'h0;
    else if (nor_q) result_d = ~alu_out;
    else if (slt_q) result_d = {31'b0, slt_bit};
  end

  // Operand/control capture on accept; held unchanged through ISSUE and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word1_q <= 32'h0;
      word2_q <= 32'h0;
      op_q    <= 2'b00;
      inv_q   <= 1'b0;
      nor_q   <= 1'b0;
      slt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      word1_q <= in_a;
      word2_q <= in_b;
      op_q    <= dec_op;
      inv_q   <= dec_inv;
      nor_q   <= dec_nor;
      slt_q   <= dec_slt;
      err_q   <= dec_err;
    end
  end

  // Result capture at the ISSUE edge; stays constant while DONE waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= 32'h0;
      out_err_q <= 1'b0;
    end else if (state_q == S_ISSUE) begin
      result_q  <= result_d;
      out_err_q <= err_q;
    end
  end

  assign alu_word1     = word1_q;
  assign alu_word2     = word2_q;
  assign alu_op        = op_q;
  assign alu_bitinvert = inv_q;
  assign out_result    = result_q;
  assign out_err       = out_err_q;

endmodule
